// File: rtl/umich_seqgen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | umich_seqgen_pipe : multi-bit generic sequential element with an           |
// |   operation-gated delay line, async clear/preset and a combinational bypass |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module umich_seqgen_pipe #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
  input  logic             clocked_on,
  input  logic             preset,
  input  logic             clear,
  input  logic [WIDTH-1:0] next_state,
  input  logic             synch_enable,
  input  logic             synch_clear,
  input  logic             synch_preset,
  input  logic             synch_toggle,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid
);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] stage0_next;
  logic             fire;
  logic             preset_only;

  // Gating preset with clear makes releasing clear while preset is held an
  // edge of its own, so the stages pick up RESET_VAL at that moment.
  assign preset_only = preset & ~clear;
  assign fire        = synch_clear | synch_preset | synch_toggle | synch_enable;

  always_comb begin
    stage0_next = next_state;
    if (synch_clear)
      stage0_next = '0;
    else if (synch_preset)
      stage0_next = RESET_VAL;
    else if (synch_toggle)
      stage0_next = stage[0] ^ next_state;
  end

  always_ff @(posedge clocked_on or posedge clear or posedge preset_only) begin
    if (clear) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
      vld <= '0;
    end else if (preset_only) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RESET_VAL;
      vld <= '0;
    end else if (fire) begin
      stage[0] <= stage0_next;
      vld[0]   <= 1'b1;
      // Shift uses pre-edge values; the line only advances on fire edges.
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
        vld[k]   <= vld[k-1];
      end
    end
  end

  always_comb begin
    if (clear)
      Q = '0;
    else if (preset)
      Q = RESET_VAL;
    else if (enable)
      Q = data_in;
    else
      Q = stage[DEPTH-1];
  end

  assign q_valid = ~clear & ~preset & (enable | vld[DEPTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_umich_seqgen_pipe.sv
`default_nettype none
// Scoreboard bench for umich_seqgen_pipe (WIDTH=8, DEPTH=3, RESET_VAL=A5):
// directed scenarios followed by randomized traffic against a queue-based model.
module tb_umich_seqgen_pipe;
  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic         clocked_on = 1'b0;
  logic         preset = 1'b0, clear = 1'b0;
  logic [W-1:0] next_state = '0, data_in = '0;
  logic         synch_enable = 1'b0, synch_clear = 1'b0;
  logic         synch_preset = 1'b0, synch_toggle = 1'b0, enable = 1'b0;
  logic [W-1:0] Q;
  logic         q_valid;

  umich_seqgen_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clocked_on(clocked_on), .preset(preset), .clear(clear),
    .next_state(next_state), .synch_enable(synch_enable),
    .synch_clear(synch_clear), .synch_preset(synch_preset),
    .synch_toggle(synch_toggle), .enable(enable), .data_in(data_in),
    .Q(Q), .q_valid(q_valid));

  always #5 clocked_on = ~clocked_on;

  typedef struct { logic [7:0] val; logic vld; } ent_t;
  typedef struct { logic [7:0] q; logic v; string name; } exp_t;

  ent_t  mp[$];   // mp[0] is stage 0, mp[D-1] drives Q
  exp_t  exp_q[$];
  int    checks = 0, failures = 0;
  event  sample_ev;

  function automatic void model_fill(logic [7:0] val);
    mp.delete();
    for (int i = 0; i < D; i++) mp.push_back('{val, 1'b0});
  endfunction

  // Level-sensitive async view plus one operation per fire edge.
  function automatic void model_edge();
    ent_t n;
    if (clear) model_fill(8'h00);
    else if (preset) model_fill(RV);
    else if (synch_clear | synch_preset | synch_toggle | synch_enable) begin
      if (synch_clear)       n.val = 8'h00;
      else if (synch_preset) n.val = RV;
      else if (synch_toggle) n.val = mp[0].val ^ next_state;
      else                   n.val = next_state;
      n.vld = 1'b1;
      mp.push_front(n);
      void'(mp.pop_back());
    end
  endfunction

  function automatic void push_exp(string name);
    exp_t e;
    e.name = name;
    if (clear)        begin e.q = 8'h00;      e.v = 1'b0; end
    else if (preset)  begin e.q = RV;         e.v = 1'b0; end
    else if (enable)  begin e.q = data_in;    e.v = 1'b1; end
    else              begin e.q = mp[D-1].val; e.v = mp[D-1].vld; end
    exp_q.push_back(e);
  endfunction

  // Monitor: checks after every clock edge and after every async/bypass change.
  initial begin
    exp_t e;
    forever begin
      @(posedge clocked_on or sample_ev);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (Q !== e.q) begin
          failures++;
          $display("FAIL %s Q: got %h expected %h", e.name, Q, e.q);
        end
        checks++;
        if (q_valid !== e.v) begin
          failures++;
          $display("FAIL %s q_valid: got %b expected %b", e.name, q_valid, e.v);
        end
      end
    end
  end

  task automatic step(input bit sc, input bit sp, input bit st, input bit se,
                      input logic [7:0] ns, input bit en, input logic [7:0] di,
                      input string name);
    @(negedge clocked_on);
    synch_clear = sc; synch_preset = sp; synch_toggle = st; synch_enable = se;
    next_state = ns; enable = en; data_in = di;
    @(posedge clocked_on);
    model_edge();
    push_exp(name);
  endtask

  // Input change between edges with no sync operation requested.
  task automatic async_set(input bit clr, input bit pre, input bit en,
                           input logic [7:0] di, input string name);
    @(negedge clocked_on);
    synch_clear = 0; synch_preset = 0; synch_toggle = 0; synch_enable = 0;
    clear = clr; preset = pre; enable = en; data_in = di;
    model_edge();
    push_exp(name);
    ->sample_ev;
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_fill(8'h00);
    // Reset without clocks, then release
    async_set(0, 1, 0, 8'h00, "preset_on");
    async_set(0, 0, 0, 8'h00, "preset_off");
    // Three loads reach Q after the third fire edge
    step(0,0,0,1, 8'h11, 0, 0, "load11");
    step(0,0,0,1, 8'h22, 0, 0, "load22");
    step(0,0,0,1, 8'h33, 0, 0, "load33");
    step(0,0,0,0, 8'hEE, 0, 0, "idle1");
    step(0,0,0,0, 8'hEE, 0, 0, "idle2");
    // Toggle and priority combinations, observed as they ripple to Q
    step(0,0,0,1, 8'h0F, 0, 0, "load0F");
    step(0,0,1,0, 8'hFF, 0, 0, "toggleFF");
    step(1,0,0,1, 8'h77, 0, 0, "clr_over_en");
    step(0,1,1,0, 8'h3C, 0, 0, "pre_over_tog");
    step(0,0,1,0, 8'h00, 0, 0, "toggle_zero");
    step(0,0,1,0, 8'h00, 0, 0, "toggle_zero2");
    // Bypass over a pipeline full of 11
    step(0,0,0,1, 8'h11, 0, 0, "fill11a");
    step(0,0,0,1, 8'h11, 0, 0, "fill11b");
    step(0,0,0,1, 8'h11, 0, 0, "fill11c");
    async_set(0, 0, 1, 8'h3C, "bypass_on");
    async_set(0, 0, 0, 8'h3C, "bypass_off");
    step(0,0,0,0, 8'h00, 0, 0, "idle_after_bypass");
    // clear+preset together mid-stream, released one at a time
    step(0,0,0,1, 8'h5A, 0, 0, "pre_stream");
    async_set(1, 1, 0, 8'h00, "clr_and_pre");
    async_set(0, 1, 0, 8'h00, "release_clr");
    async_set(0, 0, 0, 8'h00, "release_pre");
    step(0,0,0,1, 8'h61, 0, 0, "refill1");
    step(0,0,0,1, 8'h62, 0, 0, "refill2");
    step(0,0,0,1, 8'h63, 0, 0, "refill3");
    // clear arriving on the same edge as a load of 99
    @(negedge clocked_on);
    synch_enable = 1; next_state = 8'h99;
    @(posedge clocked_on);
    clear = 1;
    model_edge();
    push_exp("clr_at_edge");
    async_set(0, 0, 0, 8'h00, "clr_at_edge_rel");
    step(0,0,0,1, 8'h44, 0, 0, "post_clr1");
    step(0,0,0,1, 8'h44, 0, 0, "post_clr2");
    step(0,0,0,1, 8'h44, 0, 0, "post_clr3");
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        async_set(1, $urandom_range(0, 1), 0, 8'h00, "rnd_clear");
        async_set(0, 0, 0, 8'h00, "rnd_clear_rel");
      end else if (r < 6) begin
        async_set(0, 1, 0, 8'h00, "rnd_preset");
        async_set(0, 0, 0, 8'h00, "rnd_preset_rel");
      end else if (r < 12) begin
        async_set(0, 0, $urandom_range(0, 1), 8'($urandom), "rnd_bypass");
      end else begin
        step($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             8'($urandom), $urandom_range(0, 7) == 0, 8'($urandom), "rnd_step");
      end
    end
    repeat (4) @(negedge clocked_on);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
